// File: rtl/diff_tdm_rx.sv
// diff_tdm_rx: receiver for the 3-slot TDM differential-Manchester line.
// One line half-bit arrives per clk, so a bit takes 2 cycles and a frame
// (sync, a, b) takes 6. The receiver first finds the half-bit phase, then
// the sync slot (the only slot that toggles every frame). While locked it
// delivers each frame's a/b pair with a one-cycle valid strobe.
module diff_tdm_rx #(
  parameter int LOCK_FRAMES = 4,
  parameter int MISS_LIMIT  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic m,
  output logic a_out,
  output logic b_out,
  output logic valid,
  output logic locked,
  output logic code_err
);

  typedef enum logic [1:0] {
    HUNT_PHASE = 2'd0,
    HUNT_FRAME = 2'd1,
    LOCKED     = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [2:0] MISS_N = 3'(MISS_LIMIT);

  state_t     state;
  logic       m_q;
  logic       m_qq;
  logic       ph;
  logic       prev_h1;
  logic [2:0] good_cnt;
  logic [1:0] sc;
  logic [1:0] cand;
  logic [3:0] conf;
  logic [2:0] sv;
  logic [2:0] miss_cnt;
  logic [2:0] viol_cnt;
  logic       held_a;
  logic       a_bad;

  logic       viol;
  logic       bit_v;
  logic       sync_ok;
  logic       hit_viol;
  logic       hit_miss;
  logic [1:0] role;
  logic [1:0] sc_inc;
  logic [1:0] cand_inc;

  // Decode the current half-bit pair and work out which slot the bit occupies
  always_comb begin
    viol     = (m_qq == m_q);
    bit_v    = (m_qq == prev_h1);
    sc_inc   = (sc == 2'd2) ? 2'd0 : sc + 2'd1;
    cand_inc = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    role     = (sc >= cand) ? (sc - cand) : (sc + 2'd3 - cand);
    sync_ok  = (bit_v != sv[sc]);
    hit_viol = viol && ((viol_cnt + 3'd1) == MISS_N);
    hit_miss = (role == 2'd0) && !sync_ok && ((miss_cnt + 3'd1) == MISS_N);
  end

  // Phase recovery, frame alignment and locked-mode demultiplexing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= HUNT_PHASE;
      m_q      <= 1'b0;
      m_qq     <= 1'b0;
      ph       <= 1'b0;
      prev_h1  <= 1'b0;
      good_cnt <= 3'd0;
      sc       <= 2'd0;
      cand     <= 2'd0;
      conf     <= 4'd0;
      sv       <= 3'd0;
      miss_cnt <= 3'd0;
      viol_cnt <= 3'd0;
      held_a   <= 1'b0;
      a_bad    <= 1'b0;
      a_out    <= 1'b0;
      b_out    <= 1'b0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      code_err <= 1'b0;
    end else begin
      m_q      <= m;
      m_qq     <= m_q;
      ph       <= ~ph;
      valid    <= 1'b0;
      code_err <= 1'b0;
      if (ph) begin
        prev_h1 <= m_q;
        unique case (state)
          HUNT_PHASE: begin
            if (viol) begin
              ph       <= 1'b1;
              good_cnt <= 3'd0;
            end else if (good_cnt == 3'd5) begin
              state    <= HUNT_FRAME;
              good_cnt <= 3'd0;
              sc       <= 2'd0;
              cand     <= 2'd0;
              conf     <= 4'd0;
            end else begin
              good_cnt <= good_cnt + 3'd1;
            end
          end
          HUNT_FRAME: begin
            if (viol) begin
              state    <= HUNT_PHASE;
              good_cnt <= 3'd0;
            end else begin
              sv[sc] <= bit_v;
              sc     <= sc_inc;
              if (sc == cand) begin
                if (sync_ok) begin
                  conf <= conf + 4'd1;
                  if ((conf + 4'd1) == LOCK_N) begin
                    state    <= LOCKED;
                    locked   <= 1'b1;
                    miss_cnt <= 3'd0;
                    viol_cnt <= 3'd0;
                    a_bad    <= 1'b0;
                  end
                end else begin
                  conf <= 4'd0;
                  cand <= cand_inc;
                end
              end
            end
          end
          LOCKED: begin
            sv[sc]   <= bit_v;
            sc       <= sc_inc;
            code_err <= viol;
            viol_cnt <= viol ? viol_cnt + 3'd1 : 3'd0;
            unique case (role)
              2'd0: miss_cnt <= sync_ok ? 3'd0 : miss_cnt + 3'd1;
              2'd1: begin
                held_a <= bit_v;
                a_bad  <= viol;
              end
              2'd2: begin
                if (!viol && !a_bad) begin
                  a_out <= held_a;
                  b_out <= bit_v;
                  valid <= 1'b1;
                end
              end
              default: begin
              end
            endcase
            if (hit_viol) begin
              state    <= HUNT_PHASE;
              locked   <= 1'b0;
              good_cnt <= 3'd0;
            end else if (hit_miss) begin
              state  <= HUNT_FRAME;
              locked <= 1'b0;
              conf   <= 4'd0;
            end
          end
          default: state <= HUNT_PHASE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_diff_tdm_rx.sv
// Directed bench for diff_tdm_rx: a behavioural TDM differential-Manchester
// transmitter drives the line one half-bit per falling clock edge, and the
// receiver outputs are sampled on that same falling edge.
module tb_diff_tdm_rx;

  logic clk;
  logic rst;
  logic m;
  logic a_out;
  logic b_out;
  logic valid;
  logic locked;
  logic code_err;

  int vectors;
  int miscompares;
  int validCnt;
  int errCnt;
  int snapV;
  int snapE;
  int lockSeen;

  int   txIdx;
  logic txLevel;
  logic txH0;
  logic syncV;
  logic curA;
  logic curB;
  logic freezeSync;
  logic forceConst;
  logic corruptA;
  logic frameBits [3];

  diff_tdm_rx #(.LOCK_FRAMES(4), .MISS_LIMIT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .m        (m),
    .a_out    (a_out),
    .b_out    (b_out),
    .valid    (valid),
    .locked   (locked),
    .code_err (code_err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One half-bit: sample the receiver on the falling edge, then drive the next line level
  task automatic applyStimulus();
    logic h;
    logic drv;
    int   slot;
    @(negedge clk);
    if (valid === 1'b1) validCnt++;
    if (code_err === 1'b1) errCnt++;
    if (txIdx == 0) begin
      if (!freezeSync) syncV = ~syncV;
      frameBits[0] = syncV;
      frameBits[1] = curA;
      frameBits[2] = curB;
    end
    slot = txIdx / 2;
    if (txIdx % 2 == 0) begin
      h    = frameBits[slot] ? txLevel : ~txLevel;
      txH0 = h;
    end else begin
      h = ~txH0;
    end
    txLevel = h;
    drv     = h;
    if (txIdx == 3 && corruptA) begin
      drv      = txH0;
      corruptA = 1'b0;
    end
    if (forceConst) drv = 1'b1;
    m     = drv;
    txIdx = (txIdx == 5) ? 0 : txIdx + 1;
  endtask

  task automatic resetTx();
    txIdx      = 0;
    txLevel    = 1'b0;
    txH0       = 1'b0;
    syncV      = 1'b0;
    curA       = 1'b1;
    curB       = 1'b0;
    freezeSync = 1'b0;
    forceConst = 1'b0;
    corruptA   = 1'b0;
  endtask

  task automatic toFrameStart();
    while (txIdx != 0) applyStimulus();
  endtask

  task automatic waitLock(input string tag, input int budget);
    lockSeen = 0;
    for (int i = 0; i < budget; i++) begin
      applyStimulus();
      if (locked === 1'b1) begin
        lockSeen = 1;
        break;
      end
    end
    checkOutput(tag, 32'(lockSeen), 32'd1);
  endtask

  // Linear sequence of directed steps
  initial begin
    vectors     = 0;
    miscompares = 0;
    validCnt    = 0;
    errCnt      = 0;
    resetTx();
    rst = 1'b0;
    m   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_a_out", 32'(a_out), 32'd0);
    checkOutput("reset_b_out", 32'(b_out), 32'd0);
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_locked", 32'(locked), 32'd0);
    checkOutput("reset_code_err", 32'(code_err), 32'd0);

    // Acquisition from every half-bit / slot starting offset, then steady state
    for (int off = 0; off < 6; off++) begin
      rst = 1'b0;
      m   = 1'b0;
      repeat (2) @(negedge clk);
      resetTx();
      repeat (off) applyStimulus();
      errCnt = 0;
      rst    = 1'b1;
      waitLock($sformatf("lock_off%0d", off), 76);
      snapV = validCnt;
      repeat (36) applyStimulus();
      checkOutput($sformatf("steady_valid_off%0d", off), 32'(validCnt - snapV), 32'd6);
      checkOutput($sformatf("steady_a_off%0d", off), 32'(a_out), 32'd1);
      checkOutput($sformatf("steady_b_off%0d", off), 32'(b_out), 32'd0);
      checkOutput($sformatf("no_code_err_off%0d", off), 32'(errCnt), 32'd0);
    end

    // Data change at a frame boundary and exact output latency
    toFrameStart();
    curA = 1'b0;
    curB = 1'b1;
    repeat (12) applyStimulus();
    checkOutput("chg_old_a", 32'(a_out), 32'd0);
    checkOutput("chg_old_b", 32'(b_out), 32'd1);
    curA = 1'b1;
    curB = 1'b0;
    repeat (7) applyStimulus();
    checkOutput("chg_early_valid", 32'(valid), 32'd0);
    checkOutput("chg_early_a", 32'(a_out), 32'd0);
    checkOutput("chg_early_b", 32'(b_out), 32'd1);
    applyStimulus();
    checkOutput("chg_valid", 32'(valid), 32'd1);
    checkOutput("chg_new_a", 32'(a_out), 32'd1);
    checkOutput("chg_new_b", 32'(b_out), 32'd0);

    // Single violating half-bit in the a slot
    toFrameStart();
    corruptA = 1'b1;
    repeat (2) applyStimulus();
    snapV = validCnt;
    snapE = errCnt;
    repeat (12) applyStimulus();
    checkOutput("corrupt_code_err_cycles", 32'(errCnt - snapE), 32'd1);
    checkOutput("corrupt_valid_count", 32'(validCnt - snapV), 32'd1);
    checkOutput("corrupt_locked", 32'(locked), 32'd1);
    checkOutput("corrupt_next_a", 32'(a_out), 32'd1);
    checkOutput("corrupt_next_b", 32'(b_out), 32'd0);

    // Line stuck at 1 for 12 half-bits
    toFrameStart();
    forceConst = 1'b1;
    repeat (2) applyStimulus();
    snapV = validCnt;
    snapE = errCnt;
    repeat (3) applyStimulus();
    checkOutput("const_locked_after_1", 32'(locked), 32'd1);
    applyStimulus();
    checkOutput("const_locked_after_2", 32'(locked), 32'd0);
    repeat (6) applyStimulus();
    forceConst = 1'b0;
    checkOutput("const_code_err_cycles", 32'(errCnt - snapE), 32'd2);
    checkOutput("const_valid_count", 32'(validCnt - snapV), 32'd0);
    waitLock("relock_const", 76);

    // Sync bit frozen for 3 frames
    toFrameStart();
    snapE = errCnt;
    freezeSync = 1'b1;
    repeat (9) applyStimulus();
    checkOutput("freeze_locked_miss1", 32'(locked), 32'd1);
    applyStimulus();
    checkOutput("freeze_locked_miss2", 32'(locked), 32'd0);
    repeat (8) applyStimulus();
    freezeSync = 1'b0;
    checkOutput("freeze_no_code_err", 32'(errCnt - snapE), 32'd0);
    waitLock("relock_freeze", 76);
    snapV = validCnt;
    repeat (12) applyStimulus();
    checkOutput("freeze_steady_valid", 32'(validCnt - snapV), 32'd2);
    checkOutput("freeze_steady_a", 32'(a_out), 32'd1);
    checkOutput("freeze_steady_b", 32'(b_out), 32'd0);

    // Asynchronous reset in the middle of a frame
    repeat (3) applyStimulus();
    checkOutput("pre_rst_a_out", 32'(a_out), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_a_out", 32'(a_out), 32'd0);
    checkOutput("async_rst_b_out", 32'(b_out), 32'd0);
    checkOutput("async_rst_valid", 32'(valid), 32'd0);
    checkOutput("async_rst_locked", 32'(locked), 32'd0);
    checkOutput("async_rst_code_err", 32'(code_err), 32'd0);
    rst = 1'b1;
    waitLock("relock_rst", 76);
    snapV = validCnt;
    repeat (12) applyStimulus();
    checkOutput("rst_steady_valid", 32'(validCnt - snapV), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
